dma_chan_sched: RTL and testbench



---
 rtl/dma_chan_sched.sv | 174 +++++++++++++++++
 tb/tb_dma_chan_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chan_sched.sv
// Round-robin DMA job scheduler: picks one channel's job, tracks in-flight jobs, per-channel IDs.
// Latency: request path is combinational (0 cycles); chan_done_o pulses 1 cycle after completion.
// Backpressure: a stalled grant is locked until req_ready_i; no grant while the in-flight FIFO is full.
// Optional: define DMA_CHAN_SCHED_PRIO_EN to add prio_i high-priority candidate filtering.
module dma_chan_sched #(
  parameter int NumChan        = 4,
  parameter int ReqWidth       = 64,
  parameter int IdCounterWidth = 32,
  parameter int MaxInFlight    = 8,
  localparam int ChanIdxW      = (NumChan > 1) ? $clog2(NumChan) : 1,
  localparam int CntW          = $clog2(MaxInFlight + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumChan*ReqWidth-1:0]       req_i,
  input  logic [NumChan-1:0]                req_valid_i,
  output logic [NumChan-1:0]                req_ready_o,
`ifdef DMA_CHAN_SCHED_PRIO_EN
  input  logic [NumChan-1:0]                prio_i,
`endif
  output logic [ReqWidth-1:0]               req_o,
  output logic [ChanIdxW-1:0]               req_chan_o,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  input  logic                              rsp_valid_i,
  output logic                              rsp_ready_o,
  output logic [NumChan*IdCounterWidth-1:0] next_id_o,
  output logic [NumChan*IdCounterWidth-1:0] done_id_o,
  output logic [NumChan-1:0]                chan_done_o,
  output logic [NumChan-1:0]                busy_o
);

  localparam int PtrW = $clog2(MaxInFlight);

  // in-flight FIFO of source channels, completions come back in issue order
  logic [ChanIdxW-1:0] fifo_mem [MaxInFlight];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     fifo_cnt_q;
  logic                fifo_full, fifo_empty;

  // arbitration state
  logic                lock_q;
  logic [ChanIdxW-1:0] lock_chan_q;
  logic [ChanIdxW-1:0] last_grant_q;
  logic [NumChan-1:0]  cand;
  logic                any_cand;
  logic [ChanIdxW-1:0] rr_chan, rr_idx, sel_chan, head_chan;

  // per-channel bookkeeping
  logic [IdCounterWidth-1:0] next_id_q [NumChan];
  logic [IdCounterWidth-1:0] done_id_q [NumChan];
  logic [CntW-1:0]           outst_q   [NumChan];
  logic [NumChan-1:0]        chan_done_q;
  logic [ReqWidth-1:0]       req_arr   [NumChan];

  logic               req_hs, rsp_hs;
  logic [NumChan-1:0] push_oh, pop_oh;

  genvar g;
  for (g = 0; g < NumChan; g++) begin : g_pack
    assign req_arr[g]                                   = req_i[g*ReqWidth +: ReqWidth];
    assign next_id_o[g*IdCounterWidth +: IdCounterWidth] = next_id_q[g];
    assign done_id_o[g*IdCounterWidth +: IdCounterWidth] = done_id_q[g];
    assign busy_o[g]                                    = (outst_q[g] != '0);
  end

  // candidate set: with priority enabled, high-priority requesters shadow the rest
`ifdef DMA_CHAN_SCHED_PRIO_EN
  logic [NumChan-1:0] hi_cand;
  assign hi_cand = req_valid_i & prio_i;
  assign cand    = (|hi_cand) ? hi_cand : req_valid_i;
`else
  assign cand    = req_valid_i;
`endif

  // round-robin search starting just after the last granted channel
  always_comb begin
    rr_chan  = '0;
    rr_idx   = '0;
    any_cand = 1'b0;
    for (int k = 1; k <= NumChan; k++) begin
      rr_idx = ChanIdxW'((int'(last_grant_q) + k) % NumChan);
      if (!any_cand && cand[rr_idx]) begin
        any_cand = 1'b1;
        rr_chan  = rr_idx;
      end
    end
  end

  assign fifo_full   = (fifo_cnt_q == CntW'(MaxInFlight));
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign head_chan   = fifo_mem[rd_ptr_q];

  // a stalled offer keeps its channel; new requesters cannot preempt it
  assign sel_chan    = lock_q ? lock_chan_q : rr_chan;
  assign req_chan_o  = sel_chan;
  assign req_o       = req_arr[sel_chan];
  assign req_valid_o = rst_ni & ~fifo_full & (lock_q | any_cand);
  assign req_hs      = req_valid_o & req_ready_i;

  // completions only from a registered non-empty FIFO, so no same-cycle bypass
  assign rsp_ready_o = ~fifo_empty;
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;

  // one-hot views of the issuing and retiring channel
  always_comb begin
    push_oh = '0;
    pop_oh  = '0;
    if (req_hs) push_oh[sel_chan]  = 1'b1;
    if (rsp_hs) pop_oh[head_chan]  = 1'b1;
  end

  assign req_ready_o = push_oh;
  assign chan_done_o = chan_done_q;

  // FIFO storage needs no reset: only entries below the count are ever read
  always_ff @(posedge clk_i) begin
    if (req_hs) fifo_mem[wr_ptr_q] <= sel_chan;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (req_hs) wr_ptr_q <= (wr_ptr_q == PtrW'(MaxInFlight - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (rsp_hs) rd_ptr_q <= (rd_ptr_q == PtrW'(MaxInFlight - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (req_hs && !rsp_hs)      fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      else if (rsp_hs && !req_hs) fifo_cnt_q <= fifo_cnt_q - CntW'(1);
    end
  end

  // grant lock and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_chan_q  <= '0;
      last_grant_q <= ChanIdxW'(NumChan - 1);
    end else if (req_hs) begin
      lock_q       <= 1'b0;
      last_grant_q <= sel_chan;
    end else if (req_valid_o) begin
      lock_q       <= 1'b1;
      lock_chan_q  <= sel_chan;
    end
  end

  // per-channel ID counters and outstanding-job counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChan; c++) begin
        next_id_q[c] <= IdCounterWidth'(1);
        done_id_q[c] <= '0;
        outst_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (push_oh[c]) next_id_q[c] <= next_id_q[c] + IdCounterWidth'(1);
        if (pop_oh[c])  done_id_q[c] <= done_id_q[c] + IdCounterWidth'(1);
        if (push_oh[c] && !pop_oh[c])      outst_q[c] <= outst_q[c] + CntW'(1);
        else if (pop_oh[c] && !push_oh[c]) outst_q[c] <= outst_q[c] - CntW'(1);
      end
    end
  end

  // completion pulse, one cycle after the retiring handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) chan_done_q <= '0;
    else         chan_done_q <= pop_oh;
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Bench for dma_chan_sched: directed scenarios plus random traffic against a queue-based model.
// Model state advances on each falling edge from the inputs seen there.
// Randomised requesters hold valid/data until accepted.
module tb_dma_chan_sched;

  localparam int NC  = 4;
  localparam int RW  = 16;
  localparam int IDW = 4;
  localparam int MIF = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*RW-1:0]  req;
  logic [NC-1:0]     req_vld;
  logic [NC-1:0]     req_rdy;
  logic [NC-1:0]     prio;
  logic [RW-1:0]     req_out;
  logic [CW-1:0]     req_chan;
  logic              req_vld_o;
  logic              be_rdy;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [NC*IDW-1:0] next_id;
  logic [NC*IDW-1:0] done_id;
  logic [NC-1:0]     chan_done;
  logic [NC-1:0]     busy;

  int tests = 0;
  int fails = 0;

  dma_chan_sched #(
    .NumChan(NC), .ReqWidth(RW), .IdCounterWidth(IDW), .MaxInFlight(MIF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_valid_i (req_vld),
    .req_ready_o (req_rdy),
`ifdef DMA_CHAN_SCHED_PRIO_EN
    .prio_i      (prio),
`endif
    .req_o       (req_out),
    .req_chan_o  (req_chan),
    .req_valid_o (req_vld_o),
    .req_ready_i (be_rdy),
    .rsp_valid_i (rsp_vld),
    .rsp_ready_o (rsp_rdy),
    .next_id_o   (next_id),
    .done_id_o   (done_id),
    .chan_done_o (chan_done),
    .busy_o      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_last;
  bit         m_lock;
  int         m_lock_chan;
  int         m_q[$];
  int         m_next[NC];
  int         m_done[NC];
  logic [NC-1:0] m_pend;

  task automatic m_reset();
    m_last = NC - 1;
    m_lock = 0;
    m_lock_chan = 0;
    m_q.delete();
    for (int c = 0; c < NC; c++) begin
      m_next[c] = 1;
      m_done[c] = 0;
    end
    m_pend = '0;
  endtask

  initial m_reset();

  logic [NC-1:0] mc_cand, mc_hi, mc_busy, mc_rdy;
  int            mc_chan, mc_h;
  bit            mc_found, mc_vld;

  // compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (!rst_n) m_reset();
`ifdef DMA_CHAN_SCHED_PRIO_EN
    mc_hi = req_vld & prio;
`else
    mc_hi = '0;
`endif
    mc_cand = (|mc_hi) ? mc_hi : req_vld;
    mc_found = 0;
    mc_chan = 0;
    for (int k = 1; k <= NC; k++) begin
      if (!mc_found && mc_cand[(m_last + k) % NC]) begin
        mc_found = 1;
        mc_chan = (m_last + k) % NC;
      end
    end
    if (m_lock) mc_chan = m_lock_chan;
    mc_vld = rst_n && (m_q.size() < MIF) && (m_lock || mc_found);
    mc_busy = '0;
    foreach (m_q[i]) mc_busy[m_q[i]] = 1'b1;
    mc_rdy = '0;
    if (mc_vld && be_rdy) mc_rdy[mc_chan] = 1'b1;

    chk("m.req_valid", req_vld_o, mc_vld);
    if (mc_vld) begin
      chk("m.req_chan", req_chan, mc_chan);
      chk("m.req_data", req_out, req[mc_chan*RW +: RW]);
    end
    chk("m.req_ready", req_rdy, mc_rdy);
    chk("m.rsp_ready", rsp_rdy, m_q.size() != 0);
    chk("m.chan_done", chan_done, m_pend);
    chk("m.busy", busy, mc_busy);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("m.next_id[%0d]", c), next_id[c*IDW +: IDW], m_next[c] % (1 << IDW));
      chk($sformatf("m.done_id[%0d]", c), done_id[c*IDW +: IDW], m_done[c] % (1 << IDW));
    end

    if (rst_n) begin
      m_pend = '0;
      if (rsp_vld && m_q.size() != 0) begin
        mc_h = m_q.pop_front();
        m_done[mc_h]++;
        m_pend[mc_h] = 1'b1;
      end
      if (mc_vld && be_rdy) begin
        m_q.push_back(mc_chan);
        m_next[mc_chan]++;
        m_last = mc_chan;
        m_lock = 0;
      end else if (mc_vld) begin
        m_lock = 1;
        m_lock_chan = mc_chan;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int            rr_exp[5] = '{0, 1, 2, 3, 0};
  int            full_exp[4] = '{1, 2, 3, 0};
  logic [NC-1:0] acc;

  initial begin
    rst_n = 1'b0;
    req = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    req_vld = '0;
    prio = '0;
    be_rdy = 1'b0;
    rsp_vld = 1'b0;

    // reset values, with requesters already asserting valid
    nxt(); nxt();
    req_vld = 4'hF;
    be_rdy = 1'b1;
    smp();
    chk("rst.req_valid", req_vld_o, 0);
    chk("rst.req_ready", req_rdy, 0);
    chk("rst.rsp_ready", rsp_rdy, 0);
    chk("rst.next_id", next_id, 16'h1111);
    chk("rst.done_id", done_id, 16'h0000);
    chk("rst.busy", busy, 0);
    chk("rst.chan_done", chan_done, 0);

    // round robin with everything ready
    nxt();
    rst_n = 1'b1;
    rsp_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("rr.valid", req_vld_o, 1);
      chk("rr.chan", req_chan, rr_exp[i]);
      nxt();
    end
    req_vld = 4'b0100;
    smp();
    chk("rr.ch2", req_chan, 2);
    nxt();
    req_vld = '0;
    repeat (4) nxt();

    // lock: ch2 stalled, ch0 arrives later and must wait
    be_rdy = 1'b0;
    req_vld = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) req_vld = 4'b0101;
      smp();
      chk("lock.chan", req_chan, 2);
      chk("lock.data", req_out, 16'hC2C2);
      chk("lock.valid", req_vld_o, 1);
      nxt();
    end
    be_rdy = 1'b1;
    smp();
    chk("lock.hs_chan", req_chan, 2);
    chk("lock.hs_ready", req_rdy, 4'b0100);
    nxt();
    req_vld = 4'b0001;
    smp();
    chk("lock.next_chan", req_chan, 0);
    nxt();
    req_vld = '0;
    repeat (4) nxt();

    // full FIFO: four grants with no completions
    rsp_vld = 1'b0;
    req_vld = 4'hF;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("full.chan", req_chan, full_exp[i]);
      nxt();
    end
    smp();
    chk("full.valid", req_vld_o, 0);
    chk("full.rsp_ready", rsp_rdy, 1);
    nxt();
    rsp_vld = 1'b1;
    smp();
    chk("full.valid_on_pop", req_vld_o, 0);
    nxt();
    rsp_vld = 1'b0;
    smp();
    chk("full.done_pulse", chan_done, 4'b0010);
    chk("full.resume_valid", req_vld_o, 1);
    chk("full.resume_chan", req_chan, 1);
    nxt();
    req_vld = '0;
    rsp_vld = 1'b1;
    smp();
    chk("full.busy", busy, 4'b1111);
    nxt();
    rsp_vld = 1'b0;

    // reset with three outstanding jobs (ch3, ch0, ch1)
    rst_n = 1'b0;
    req_vld = 4'hF;
    smp();
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.next_id", next_id, 16'h1111);
    chk("mid_rst.done_id", done_id, 16'h0000);
    chk("mid_rst.chan_done", chan_done, 0);
    chk("mid_rst.rsp_ready", rsp_rdy, 0);
    chk("mid_rst.req_valid", req_vld_o, 0);
    nxt();
    req_vld = '0;
    rsp_vld = 1'b1;
    smp();
    chk("mid_rst.chan_done2", chan_done, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("post_rst.chan_done", chan_done, 0);
      chk("post_rst.rsp_ready", rsp_rdy, 0);
      nxt();
    end

    // ID wrap on ch1
    req_vld = 4'b0010;
    be_rdy = 1'b1;
    rsp_vld = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      nxt();
      if (k == 16) req_vld = '0;
      smp();
      chk("wrap.next_id1", next_id[7:4], (1 + k) % 16);
    end
    repeat (4) nxt();
    smp();
    chk("wrap.done_id1", done_id[7:4], 0);
    chk("wrap.busy1", busy[1], 0);
    nxt();

`ifdef DMA_CHAN_SCHED_PRIO_EN
    // high priority ch3 dominates, then round robin among the rest
    prio = 4'b1000;
    req_vld = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("prio.ch3", req_chan, 3);
      nxt();
    end
    req_vld = 4'b0011;
    smp();
    chk("prio.ch0", req_chan, 0);
    nxt();
    smp();
    chk("prio.ch1", req_chan, 1);
    nxt();
    req_vld = '0;
    prio = '0;
    repeat (4) nxt();
`endif

    // random traffic; model checks every cycle
    acc = '0;
    for (int n = 0; n < 2000; n++) begin
      smp();
      acc = req_rdy;
      nxt();
      rst_n = ($urandom_range(0, 249) != 0);
      for (int c = 0; c < NC; c++) begin
        if (!(req_vld[c] && !acc[c])) begin
          req_vld[c] = ($urandom_range(0, 3) != 0);
          req[c*RW +: RW] = RW'($urandom);
        end
      end
`ifdef DMA_CHAN_SCHED_PRIO_EN
      prio = NC'($urandom_range(0, 15)) & NC'($urandom_range(0, 15));
`endif
      be_rdy = ($urandom_range(0, 3) != 0);
      rsp_vld = (n < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
    end
    smp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
